// File: rtl/mod_inv_if.sv
// Ready/valid bundle for the modular inverse unit:
// operand in on one side, inverse and zero flag out on the other.
interface mod_inv_if #(
  parameter int W = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] inv_o;
  logic         zero_o;

  modport master (
    output in_valid, a_i, out_ready,
    input  in_ready, out_valid, inv_o, zero_o
  );

  modport slave (
    input  in_valid, a_i, out_ready,
    output in_ready, out_valid, inv_o, zero_o
  );
endinterface

// File: rtl/mod_inv.sv
// Modular inverse a^(Q-2) mod Q by left-to-right square-and-multiply,
// one Barrett multiply-reduce per cycle, ready/valid on both sides.
module mod_inv #(
  parameter int Q       = 3329,
  parameter int COEFF_W = 12,
  parameter int E_W     = 12
) (
  input logic      clk,
  input logic      rst,
  mod_inv_if.slave bus
);
  localparam int PW = 2 * COEFF_W;
  localparam int KW = $clog2(E_W);
  localparam int RS = 36;
  localparam logic [E_W-1:0] E  = E_W'(Q - 2);
  localparam logic [PW-1:0]  QP = PW'(Q);
  localparam logic [63:0]    BM = (64'd1 << RS) / 64'(Q);

  typedef enum logic [1:0] {
    IDLE,
    SQR,
    MUL,
    DONE
  } state_t;

  state_t             state;
  logic [COEFF_W-1:0] acc;
  logic [COEFF_W-1:0] base;
  logic [KW-1:0]      k;

  logic [COEFF_W-1:0] opb;
  logic [PW-1:0]      prod;
  logic [63:0]        qm;
  logic [PW-1:0]      qe;
  logic [PW-1:0]      rem;
  logic [COEFF_W-1:0] mul_r;

  // Barrett estimate is at most one short, so one conditional subtract
  // covers every product up to 4095*4095.
  always_comb begin
    opb   = (state == MUL) ? base : acc;
    prod  = PW'(acc) * PW'(opb);
    qm    = 64'(prod) * BM;
    qe    = PW'(qm >> RS);
    rem   = prod - qe * QP;
    mul_r = COEFF_W'((rem >= QP) ? rem - QP : rem);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      base          <= '0;
      k             <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.inv_o     <= '0;
      bus.zero_o    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            base         <= bus.a_i;
            acc          <= bus.a_i;
            k            <= KW'(E_W - 2);
            bus.in_ready <= 1'b0;
            state        <= SQR;
          end
        end
        SQR: begin
          acc <= mul_r;
          if (E[k]) begin
            state <= MUL;
          end else if (k == '0) begin
            state <= DONE;
          end else begin
            k <= k - 1'b1;
          end
        end
        MUL: begin
          acc <= mul_r;
          if (k == '0) begin
            state <= DONE;
          end else begin
            k     <= k - 1'b1;
            state <= SQR;
          end
        end
        DONE: begin
          if (!bus.out_valid) begin
            bus.out_valid <= 1'b1;
            bus.inv_o     <= acc;
            bus.zero_o    <= (acc == '0);
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.inv_o     <= '0;
            bus.zero_o    <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mod_inv.md
Name: mod_inv

Overview:
- Iterative modular inverse for ML-KEM coefficients: result = a^(Q-2) mod Q, so (a * result) mod Q = 1 for a != 0 (Fermat's little theorem).
- Inverse companion to the coefficient multiplier datapath. Used for scaling-constant generation and the inverse-NTT factor.
- Left-to-right square-and-multiply over a fixed exponent, using one internal registered multiply-reduce unit.
- Ready/valid handshake on both input and output; one operation in flight at a time.

Parameters:
- Q, 3329: prime modulus; exponent E = Q-2 = 3327 = 12'b1100_1111_1111.
- COEFF_W, 12: coefficient width, ceil(log2(Q)).
- E_W, 12: exponent width (bits of Q-2, MSB set).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand a valid
- in_ready  out  1  block can accept operand (high only in IDLE)
- a_i  in  COEFF_W  operand; any 12-bit value, treated as a mod Q
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- inv_o  out  COEFF_W  a^(Q-2) mod Q, range 0..Q-1
- zero_o  out  1  high with out_valid when (a mod Q) == 0 (no inverse exists; inv_o = 0)

Behaviour:
- Reset (rst=1 at a clock edge, from any state, including mid-computation):
  - State goes to IDLE.
  - in_ready = 1, out_valid = 0, inv_o = 0, zero_o = 0.
  - Accumulator, base, bit index and phase registers are cleared.
  - Any in-flight operand is discarded without producing a result.
- States and transitions:
  - IDLE: in_ready = 1. On in_valid && in_ready, register base = a_i and acc = a_i (this accounts for the exponent MSB), set bit index k = E_W-2, then go to SQR.
  - SQR: acc <= (acc*acc) mod Q. If E[k] = 1, go to MUL. Otherwise, if k == 0 go to DONE, else k <= k-1 and stay in SQR.
  - MUL: acc <= (acc*base) mod Q. If k == 0 go to DONE, else k <= k-1 and go to SQR.
  - DONE: out_valid = 1, inv_o = acc, zero_o = (acc == 0). On out_valid && out_ready, return to IDLE and drop out_valid the next cycle.
- Multiply-reduce unit:
  - Full 24-bit product, reduced to 0..Q-1 within the same cycle; the result is written to acc at the clock edge.
  - Each SQR/MUL state performs exactly one operation per cycle.
  - Operands may be up to 4095 (the first square of an unreduced a_i), so reduction must be correct for products up to 4095*4095.
- Latency for Q = 3329:
  - Schedule is 11 squares + 9 multiplies = 20 op cycles.
  - Accept edge at cycle 0; out_valid first high in cycle 21.
  - Latency is data-independent, including a = 0.
- Throughput:
  - in_ready is 0 from the accept edge until the cycle after output acceptance, so the next accept is possible no earlier than cycle 22.
  - in_valid is ignored outside IDLE.
- Backpressure: while out_ready = 0 in DONE, inv_o and zero_o stay stable and out_valid stays high indefinitely.
- Simultaneous events:
  - out_ready asserted in the same cycle out_valid rises: the handshake completes that cycle.
  - out_ready high while out_valid = 0: ignored.
  - rst with in_valid: reset wins and no accept occurs.
- Outputs are registered; no combinational path from in_valid/out_ready to inv_o.

Test Plan:
- Reset then a_i = 2 with out_ready = 1: in_ready drops the cycle after accept; out_valid rises exactly 21 cycles after accept with inv_o = 1665, zero_o = 0.
- Sequential operands 1, 3, 17, 3328, each with out_ready = 1: inv_o = 1, 1110, 1175, 3328 respectively; every accept-to-valid gap is 21 cycles.
- a_i = 0, then a_i = 3329: both give inv_o = 0, zero_o = 1. Then a_i = 3331 gives 1665, the same as a = 2.
- a_i = 17 with out_ready held low for 10 cycles after out_valid rises: inv_o stays 1175, out_valid stays high, in_ready stays 0 and in_valid pulses are ignored; raising out_ready completes the handshake and returns in_ready = 1 the next cycle.
- Assert rst at cycle 8 of a computation for a = 5: outputs return to reset values the next cycle and no result is produced. A following a = 5 yields inv_o = 666 (5*666 = 3330).
- Random sweep over all a in 1..3328: (a * inv_o) mod Q == 1 for every a; latency is constant.
